// File: rtl/lsnn_pkg.sv
// Shared constants and types for the adaptive LIF (LSNN-style) neuron.
//   LEAK_SHIFT : potential decays by V >> LEAK_SHIFT each cycle
//   TH_BASE    : resting / reset threshold
//   TH_INC     : threshold bump per spike
//   TH_DEC     : threshold relaxation step per quiet cycle
//   TH_MAX     : threshold ceiling
package lsnn_pkg;

  typedef logic [7:0] word_t;

  localparam int unsigned LEAK_SHIFT = 2;
  localparam word_t       TH_BASE    = 8'h40;
  localparam word_t       TH_INC     = 8'h10;
  localparam word_t       TH_DEC     = 8'h01;
  localparam word_t       TH_MAX     = 8'hF0;

endpackage

// File: rtl/lsnn_threshold_adapt.sv
// Next-state logic for the adaptive firing threshold.
//   th      : current threshold
//   fire    : neuron fires on this edge
//   th_next : threshold after this edge; saturating increment on fire,
//             floor-clamped decay toward the baseline otherwise
module lsnn_threshold_adapt
  import lsnn_pkg::*;
#(
  parameter word_t ThBase = TH_BASE,
  parameter word_t ThInc  = TH_INC,
  parameter word_t ThDec  = TH_DEC,
  parameter word_t ThMax  = TH_MAX
) (
  input  word_t th,
  input  logic  fire,
  output word_t th_next
);

  logic [8:0] th_inc;
  logic [8:0] th_dec;

  // 9-bit arithmetic so neither the increment nor the decrement can wrap
  assign th_inc = {1'b0, th} + {1'b0, ThInc};
  assign th_dec = {1'b0, th} - {1'b0, ThDec};

  always_comb begin
    th_next = th;
    if (fire) begin
      th_next = (th_inc > {1'b0, ThMax}) ? ThMax : th_inc[7:0];
    end else if (th > ThBase) begin
      // th_dec[8] flags a borrow, which can only mean we went below the floor
      th_next = (th_dec[8] || (th_dec[7:0] < ThBase)) ? ThBase : th_dec[7:0];
    end
  end

endmodule

// File: rtl/tt_um_lsnn.sv
// Single adaptive leaky integrate-and-fire neuron tile.
//   clk     : rising-edge clock
//   rst_n   : synchronous reset, active HIGH despite the name
//   ui_in   : unsigned input current, integrated every cycle
//   uo_out  : [7] spike pulse, [6:0] potential V[7:1]
//   uio_out : live firing threshold
// All outputs come straight from registers, one cycle after the input.
module tt_um_lsnn
  import lsnn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out
);

  word_t      v_q, v_d;
  word_t      th_q, th_d;
  logic       spk_q, spk_d;

  word_t      leaked;
  logic [8:0] sum_wide;
  word_t      sum;
  logic       fire;

  assign leaked   = v_q - (v_q >> LEAK_SHIFT);
  assign sum_wide = {1'b0, leaked} + {1'b0, ui_in};
  assign sum      = sum_wide[8] ? 8'hFF : sum_wide[7:0];
  assign fire     = (sum >= th_q);

  lsnn_threshold_adapt u_threshold_adapt (
    .th      (th_q),
    .fire    (fire),
    .th_next (th_d)
  );

  always_comb begin
    spk_d = fire;
    v_d   = fire ? 8'h00 : sum;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      v_q   <= 8'h00;
      th_q  <= TH_BASE;
      spk_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      th_q  <= th_d;
      spk_q <= spk_d;
    end
  end

  assign uo_out  = {spk_q, v_q[7:1]};
  assign uio_out = th_q;

endmodule

// File: tb/tb_tt_um_lsnn.sv
// Self-checking bench for tt_um_lsnn. A behavioural neuron model predicts
// every registered output; predictions are queued when stimulus is driven
// and a monitor pops and compares them after each rising edge. Scenario
// tasks add their own inline checks against hand-derived constants.
module tb_tt_um_lsnn;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];

  // behavioural model state
  int m_v  = 0;
  int m_th = 64;
  int m_spk = 0;

  tt_um_lsnn dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_out (uio_out)
  );

  always #5 clk = ~clk;

  // scoreboard monitor
  always @(posedge clk) begin
    logic [15:0] exp;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if ({uo_out, uio_out} !== exp) begin
        errors++;
        $display("FAIL scoreboard t=%0t: uo_out=%h uio_out=%h expected uo_out=%h uio_out=%h",
                 $time, uo_out, uio_out, exp[15:8], exp[7:0]);
      end
    end
  end

  // drive one cycle of stimulus, advance the model, queue its prediction
  task automatic drive(input logic r, input logic [7:0] in);
    int leaked;
    int sum;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
    rst_n = r;
    ui_in = in;
    if (r) begin
      m_v = 0; m_th = 64; m_spk = 0;
    end else begin
      leaked = m_v - (m_v / 4);
      sum = leaked + int'(in);
      if (sum > 255) sum = 255;
      if (sum >= m_th) begin
        m_spk = 1;
        m_v = 0;
        m_th = (m_th + 16 > 240) ? 240 : m_th + 16;
      end else begin
        m_spk = 0;
        m_v = sum;
        if (m_th > 64) m_th = (m_th - 1 < 64) ? 64 : m_th - 1;
      end
    end
    exp_uo  = {m_spk[0], 7'(m_v / 2)};
    exp_uio = 8'(m_th);
    exp_q.push_back({exp_uo, exp_uio});
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    drive(1'b1, 8'hFF);
    drive(1'b1, 8'hFF);
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h40) begin
      errors++;
      $display("FAIL reset: uo_out=%h uio_out=%h expected 00/40", uo_out, uio_out);
    end
  endtask

  task automatic test_integrate();
    logic [7:0] exp_uo[4] = '{8'h08, 8'h0E, 8'h12, 8'h16};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h10);
      checks++;
      if (uo_out !== exp_uo[i] || uio_out !== 8'h40) begin
        errors++;
        $display("FAIL integrate[%0d]: uo_out=%h uio_out=%h expected %h/40",
                 i, uo_out, uio_out, exp_uo[i]);
      end
    end
  endtask

  task automatic test_relax();
    logic [7:0] exp_th;
    drive(1'b1, 8'h00);
    drive(1'b0, 8'h99);
    checks++;
    if (uo_out !== 8'h80 || uio_out !== 8'h50) begin
      errors++;
      $display("FAIL strong_input: uo_out=%h uio_out=%h expected 80/50", uo_out, uio_out);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 8'h00);
      exp_th = (i < 15) ? 8'(8'h4F - i) : 8'h40;
      checks++;
      if (uo_out[7] !== 1'b0 || uio_out !== exp_th) begin
        errors++;
        $display("FAIL relax[%0d]: spike=%b uio_out=%h expected 0/%h",
                 i, uo_out[7], uio_out, exp_th);
      end
    end
  endtask

  task automatic test_equality();
    drive(1'b1, 8'h00);
    drive(1'b0, 8'h40);
    checks++;
    if (uo_out !== 8'h80 || uio_out !== 8'h50) begin
      errors++;
      $display("FAIL equal_fires: uo_out=%h uio_out=%h expected 80/50", uo_out, uio_out);
    end
    drive(1'b1, 8'h00);
    drive(1'b0, 8'h3F);
    checks++;
    if (uo_out !== 8'h1F || uio_out !== 8'h40) begin
      errors++;
      $display("FAIL below_quiet: uo_out=%h uio_out=%h expected 1F/40", uo_out, uio_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_th;
    drive(1'b1, 8'h00);
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 8'hFF);
      exp_th = (i < 10) ? 8'(8'h50 + 8'h10 * i) : 8'hF0;
      checks++;
      if (uo_out !== 8'h80 || uio_out !== exp_th) begin
        errors++;
        $display("FAIL ceiling[%0d]: uo_out=%h uio_out=%h expected 80/%h",
                 i, uo_out, uio_out, exp_th);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h00);
    for (int i = 0; i < 7; i++) drive(1'b0, 8'hFF);
    for (int i = 0; i < 16; i++) drive(1'b0, 8'h10);
    checks++;
    if (uio_out !== 8'hA0 || uo_out[6:0] === 7'h00) begin
      errors++;
      $display("FAIL mid_setup: uo_out=%h uio_out=%h expected nonzero V / A0",
               uo_out, uio_out);
    end
    drive(1'b1, 8'hFF);
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h40) begin
      errors++;
      $display("FAIL mid_reset: uo_out=%h uio_out=%h expected 00/40", uo_out, uio_out);
    end
    drive(1'b0, 8'h10);
    checks++;
    if (uo_out !== 8'h08 || uio_out !== 8'h40) begin
      errors++;
      $display("FAIL post_reset: uo_out=%h uio_out=%h expected 08/40", uo_out, uio_out);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    ui_in = 8'h00;
    test_reset();
    test_integrate();
    test_relax();
    test_equality();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
